// File: rtl/target_port_pkg.sv
// target_port_pkg
// Shared types and default sizes for the target-side serial bus interface.
// Contents:
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH - default serial field lengths
//   tgt_state_t                     - transaction state encoding
package target_port_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ADDR,
    WDATA,
    WSTB,
    WACK,
    RD_REQ,
    RD_WAIT,
    RSEND,
    RACK
  } tgt_state_t;

endpackage

// File: rtl/serial_shift_rx.sv
// serial_shift_rx
// LSB-first serial deserializer. Each enabled cycle shifts bit_i in at the
// top of the word; done_o pulses combinationally on the cycle the final bit
// is presented, with word_o already holding the completed word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - restart the bit count (the current bit, if any, is bit 0)
//   shift_en_i  - bit_i is valid and belongs to this field
//   bit_i       - serial input bit
//   word_o      - word including the bit shifted in this cycle
//   done_o      - last bit of the field is being shifted in this cycle
module serial_shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;

  // Next shift value and bit count. A clear in the same cycle as a shift
  // makes the incoming bit the first bit of a fresh field.
  always_comb begin
    cnt_base = clear_i ? '0 : cnt_q;
    shift_d  = shift_q;
    cnt_d    = cnt_base;
    done_o   = 1'b0;
    if (shift_en_i) begin
      shift_d = {bit_i, shift_q[WIDTH-1:1]};
      if (cnt_base == LAST) begin
        done_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  assign word_o = shift_d;

  // Shift register and bit counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/target_port.sv
// target_port
// Target end of the serial initiator link. Deserializes a LSB-first address
// (bus_mode=0) and, for writes, LSB-first write data (bus_mode=1), decodes the
// address against a base/mask window and issues a single-cycle access to the
// local memory. Reads optionally signal a split, then return the byte serially
// on bus_data_in once the bus is idle in data mode, followed by an ack.
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   bus_data_out/_valid, bus_mode     - serial stream from the initiator
//   bus_init_rw                       - 1 write / 0 read, taken with last addr bit
//   bus_data_in/_valid                - serial read data to the initiator
//   target_ack, target_split          - one-cycle completion / split pulses
//   mem_addr, mem_wdata               - latched access address / write data
//   mem_wr_en, mem_rd_en              - one-cycle memory strobes
//   mem_rdata, mem_rdata_valid        - memory read return
module target_port
  import target_port_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = '0,
  parameter bit                    SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_data_out,
  input  logic                  bus_data_out_valid,
  input  logic                  bus_mode,
  input  logic                  bus_init_rw,
  output logic                  bus_data_in,
  output logic                  bus_data_in_valid,
  output logic                  target_ack,
  output logic                  target_split,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tgt_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic                  rbuf_full_q, rbuf_full_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;

  logic bus_data_in_q, bus_data_in_valid_q, target_ack_q, target_split_q;
  logic mem_wr_en_q, mem_rd_en_q;

  logic                  addr_shift, addr_clear, addr_done, addr_hit;
  logic                  data_shift, data_clear, data_done, wdata_abort;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic [DATA_WIDTH-1:0] data_word;

  // An address-mode bit during WDATA abandons the write and is taken as the
  // first bit of a new address, so the address shifter restarts its count.
  assign wdata_abort = (state_q == WDATA) && bus_data_out_valid && !bus_mode;
  assign addr_shift  = bus_data_out_valid && !bus_mode &&
                       ((state_q == ADDR) || (state_q == WDATA));
  assign addr_clear  = (state_q == WDATA);
  assign data_shift  = bus_data_out_valid && bus_mode && (state_q == WDATA);
  assign data_clear  = (state_q != WDATA) || wdata_abort;
  assign addr_hit    = (addr_word & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);

  serial_shift_rx #(.WIDTH(ADDR_WIDTH)) u_addr_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (addr_clear),
    .shift_en_i (addr_shift),
    .bit_i      (bus_data_out),
    .word_o     (addr_word),
    .done_o     (addr_done)
  );

  serial_shift_rx #(.WIDTH(DATA_WIDTH)) u_data_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (data_clear),
    .shift_en_i (data_shift),
    .bit_i      (bus_data_out),
    .word_o     (data_word),
    .done_o     (data_done)
  );

  // Next-state logic. In RD_WAIT the freshly captured byte counts toward the
  // send condition, so data and bus idle arriving together start RSEND.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rbuf_d      = rbuf_q;
    rbuf_full_d = rbuf_full_q;
    bit_cnt_d   = bit_cnt_q;
    unique case (state_q)
      ADDR: begin
        if (addr_done) begin
          mem_addr_d = addr_word;
          if (addr_hit) state_d = bus_init_rw ? WDATA : RD_REQ;
        end
      end
      WDATA: begin
        if (wdata_abort) begin
          state_d = ADDR;
        end else if (data_done) begin
          mem_wdata_d = data_word;
          state_d     = WSTB;
        end
      end
      WSTB:   state_d = WACK;
      WACK:   state_d = ADDR;
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_rdata_valid) begin
          rbuf_d      = mem_rdata;
          rbuf_full_d = 1'b1;
        end
        if (rbuf_full_d && bus_mode && !bus_data_out_valid) begin
          state_d   = RSEND;
          bit_cnt_d = '0;
        end
      end
      RSEND: begin
        if (bit_cnt_q == LAST_BIT) state_d = RACK;
        else                       bit_cnt_d = bit_cnt_q + 1'b1;
      end
      RACK: begin
        rbuf_full_d = 1'b0;
        state_d     = ADDR;
      end
      default: state_d = ADDR;
    endcase
  end

  // State register. Outputs are registered from the next state so each
  // strobe/pulse is high for exactly the cycle spent in its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= ADDR;
      mem_addr_q          <= '0;
      mem_wdata_q         <= '0;
      rbuf_q              <= '0;
      rbuf_full_q         <= 1'b0;
      bit_cnt_q           <= '0;
      bus_data_in_q       <= 1'b0;
      bus_data_in_valid_q <= 1'b0;
      target_ack_q        <= 1'b0;
      target_split_q      <= 1'b0;
      mem_wr_en_q         <= 1'b0;
      mem_rd_en_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      mem_addr_q          <= mem_addr_d;
      mem_wdata_q         <= mem_wdata_d;
      rbuf_q              <= rbuf_d;
      rbuf_full_q         <= rbuf_full_d;
      bit_cnt_q           <= bit_cnt_d;
      bus_data_in_q       <= (state_d == RSEND) ? rbuf_d[bit_cnt_d] : 1'b0;
      bus_data_in_valid_q <= (state_d == RSEND);
      target_ack_q        <= (state_d == WACK) || (state_d == RACK);
      target_split_q      <= SPLIT_EN && (state_d == RD_REQ);
      mem_wr_en_q         <= (state_d == WSTB);
      mem_rd_en_q         <= (state_d == RD_REQ);
    end
  end

  assign bus_data_in       = bus_data_in_q;
  assign bus_data_in_valid = bus_data_in_valid_q;
  assign target_ack        = target_ack_q;
  assign target_split      = target_split_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_wr_en         = mem_wr_en_q;
  assign mem_rd_en         = mem_rd_en_q;

endmodule

// File: doc/target_port.md
# target_port

Target-side serial bus interface, the far end of the initiator's `init_port` link. It deserializes the 16-bit address (LSB first, `bus_mode`=0) and, for writes, the 8-bit write data (LSB first, `bus_mode`=1). It decodes the address against a base/mask window and issues a single-cycle memory access to the local target memory. Writes are acknowledged with `target_ack`; reads raise `target_split` (when enabled) and the returned byte is serialized back on `bus_data_in`, followed by `target_ack`.

## Interface
- `ADDR_WIDTH`, 16, serial address length in bits.
- `DATA_WIDTH`, 8, serial data length in bits.
- `BASE_ADDR`, 16'h0000, decode window base.
- `ADDR_MASK`, 16'h0000, decode mask. The address matches when `(addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)`.
- `SPLIT_EN`, 1, pulse `target_split` on every accepted read.
- `clk  in  1` — single clock, all logic on posedge.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `bus_data_out  in  1` — serial bit from the initiator.
- `bus_data_out_valid  in  1` — `bus_data_out` is valid this cycle.
- `bus_mode  in  1` — 0 = address phase, 1 = data phase.
- `bus_init_rw  in  1` — 1 = write, 0 = read; sampled with the last address bit.
- `bus_data_in  out  1` — serial read-data bit to the initiator.
- `bus_data_in_valid  out  1` — `bus_data_in` is valid.
- `target_ack  out  1` — one-cycle completion pulse.
- `target_split  out  1` — one-cycle split pulse.
- `mem_addr  out  ADDR_WIDTH` — latched access address.
- `mem_wdata  out  DATA_WIDTH` — latched write data.
- `mem_wr_en  out  1` — one-cycle write strobe.
- `mem_rd_en  out  1` — one-cycle read strobe.
- `mem_rdata  in  DATA_WIDTH` — read data.
- `mem_rdata_valid  in  1` — `mem_rdata` is valid; arrives any number of cycles (≥1) after `mem_rd_en`.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, `mem_addr`/`mem_wdata` = 0, state ADDR, all counters 0.
- ADDR state:
  - Each cycle with `bus_data_out_valid && !bus_mode`: shift in `{bus_data_out, shift[15:1]}` and increment `addr_cnt`.
  - On the 16th bit: latch `mem_addr` and `bus_init_rw`, clear `addr_cnt`.
  - No decode match: stay in ADDR; no strobe, no ack.
  - Match with rw=1: go to WDATA. Match with rw=0: go to RD_REQ.
- WDATA state:
  - Shift bits on `bus_data_out_valid && bus_mode`.
  - On the 8th bit: latch `mem_wdata` and go to WSTB.
  - Valid bits with `bus_mode`=0 arriving in WDATA abort: clear counters and return to ADDR, treating that bit as address bit 0.
- WSTB: `mem_wr_en`=1 for one cycle, then WACK.
- WACK: `target_ack`=1 for one cycle, then ADDR.
- RD_REQ: `mem_rd_en`=1 for one cycle; `target_split`=1 in the same cycle if `SPLIT_EN`. Then RD_WAIT.
- RD_WAIT:
  - Capture `mem_rdata` into `rbuf` when `mem_rdata_valid`; set `rbuf_full`.
  - Go to RSEND when `rbuf_full && bus_mode && !bus_data_out_valid`.
  - Data valid in the same cycle as the bus condition counts; it is captured and the transition occurs.
- RSEND: 8 consecutive cycles of `bus_data_in_valid`=1 with `bus_data_in = rbuf[bit_cnt]`, `bit_cnt` 0..7. After bit 7, go to RACK. No stalling mid-byte.
- RACK: `target_ack`=1 for one cycle; clear `rbuf_full`; go to ADDR.
- `mem_rdata_valid` outside RD_WAIT is ignored.
- `bus_data_out_valid` during WSTB/WACK/RD_REQ/RSEND/RACK is ignored.
- Asynchronous reset mid-transaction returns everything to reset values at once; no partial strobe or ack is emitted afterwards.

## Timing
- Write: last data bit sampled at edge N → `mem_wr_en` high in cycle N+1 → `target_ack` high in cycle N+2.
- Read: 16th address bit sampled at edge N → `mem_rd_en` and `target_split` high in cycle N+1.
- Read data: `mem_rdata_valid` at edge M with the bus condition met → first `bus_data_in_valid` in cycle M+1, last in cycle M+8, `target_ack` in cycle M+9.
- Minimum gap between a completed transaction and the next accepted address bit: 0 cycles, since ADDR is reentered on the ack cycle's following edge.

## Structure
- Package `target_port_pkg` holds:
  - `tgt_state_t` enum: ADDR, WDATA, WSTB, WACK, RD_REQ, RD_WAIT, RSEND, RACK.
  - Default `ADDR_WIDTH`/`DATA_WIDTH` constants.
- One sub-module is natural: `serial_shift_rx` (parameterized width, LSB-first shift plus done pulse), instantiated for both address and data.

## Test plan
- Write to 0x0012 with data 0x3C, mask 0 → `mem_wr_en` once with `mem_addr`=0x0012 and `mem_wdata`=0x3C; `target_ack` exactly one cycle, two cycles after the last bit.
- Read 0x0034, memory returns 0x96 after 4 cycles, bus idle in data mode → one `target_split` pulse; `bus_data_in` bits 0,1,1,0,1,0,0,1 over 8 valid cycles; one `target_ack`.
- `BASE_ADDR`=0x1000, `ADDR_MASK`=0xF000, write to 0x2012 → no `mem_wr_en`, no ack. A following write to 0x1012 with data 0x55 completes normally.
- `SPLIT_EN`=0, read with zero-wait data (valid one cycle after `mem_rd_en`) → `target_split` never asserted; byte returned starting the next cycle.
- Read data returned while `bus_data_out_valid`=1 → serialization waits until `bus_data_out_valid` drops, then the full byte is sent.
- Reset asserted during RSEND bit 3 → `bus_data_in_valid` and `target_ack` go to 0 immediately and stay 0. A subsequent write succeeds.
